// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle pulled-up lines read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, per-scan snapshot, debounced press/release.
//   state    | meaning
//   IDLE     | no key accepted; waiting for a scan with exactly one key
//   DEBOUNCE | candidate key seen on consecutive scans, counting toward acceptance
//   PRESSED  | key accepted and held; waiting for it to disappear
//   RELEASE  | candidate absent, counting clean scans before declaring release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_ROWS-1:0]   row_n,
  output logic [KEY_COLS-1:0]   col_n,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_held,
  output logic                  multi_key
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DS_C     = CW'(DEBOUNCE_SCANS);

  logic [KEY_ROWS-1:0]   row_s;
  logic [DW-1:0]         dwell;
  logic [1:0]            col_idx;
  logic [15:0]           snapshot, snap_now;
  logic                  sample, scan_end, single, cand_hit;
  logic [4:0]            n_keys;
  logic [KEY_CODE_W-1:0] hit_code;

  kp_state_e             state, state_n;
  logic [KEY_CODE_W-1:0] cand, cand_n, key_code_n;
  logic [CW-1:0]         cnt, cnt_n, cnt_inc, rcnt, rcnt_n, rcnt_inc;
  logic                  key_valid_n, key_held_n;

  sync_2ff #(.WIDTH(KEY_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  assign col_n    = ~(4'b0001 << col_idx);
  assign sample   = (dwell == DIV_LAST);
  assign scan_end = sample && (col_idx == 2'd3);

  // Snapshot including the column being sampled this cycle, so scan end sees all 16 keys.
  always_comb begin
    snap_now = snapshot;
    if (sample) begin
      for (int r = 0; r < KEY_ROWS; r++) snap_now[r*KEY_COLS + int'(col_idx)] = ~row_s[r];
    end
  end

  always_comb begin
    hit_code = '0;
    for (int i = 0; i < 16; i++) if (snap_now[i]) hit_code = KEY_CODE_W'(i);
  end

  assign n_keys   = popcount16(snap_now);
  assign single   = (n_keys == 5'd1);
  assign cand_hit = snap_now[cand];
  assign cnt_inc  = (cnt == DS_C) ? cnt : cnt + 1'b1;
  assign rcnt_inc = (rcnt == DS_C) ? rcnt : rcnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell     <= '0;
      col_idx   <= '0;
      snapshot  <= '0;
      multi_key <= 1'b0;
    end else if (sample) begin
      dwell    <= '0;
      col_idx  <= col_idx + 2'd1;
      snapshot <= snap_now;
      if (scan_end) multi_key <= (n_keys >= 5'd2);
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      key_valid <= key_valid_n;
      key_code  <= key_code_n;
      key_held  <= key_held_n;
    end
  end

  always_comb begin
    state_n     = state;
    cand_n      = cand;
    cnt_n       = cnt;
    rcnt_n      = rcnt;
    key_valid_n = 1'b0;
    key_code_n  = key_code;
    key_held_n  = key_held;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n = hit_code;
            if (DEBOUNCE_SCANS <= 1) begin
              key_valid_n = 1'b1;
              key_code_n  = hit_code;
              key_held_n  = 1'b1;
              cnt_n       = '0;
              state_n     = PRESSED;
            end else begin
              cnt_n   = CW'(1);
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (single && hit_code == cand) begin
            if (cnt_inc >= DS_C) begin
              key_valid_n = 1'b1;
              key_code_n  = cand;
              key_held_n  = 1'b1;
              cnt_n       = '0;
              state_n     = PRESSED;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (!cand_hit) begin
            if (DEBOUNCE_SCANS <= 1) begin
              key_held_n = 1'b0;
              rcnt_n     = '0;
              state_n    = IDLE;
            end else begin
              rcnt_n  = CW'(1);
              state_n = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (cand_hit) begin
            rcnt_n  = '0;
            state_n = PRESSED;
          end else if (rcnt_inc >= DS_C) begin
            key_held_n = 1'b0;
            rcnt_n     = '0;
            state_n    = IDLE;
          end else begin
            rcnt_n = rcnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;
  logic       clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       multi_key;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int p0;
  logic prev_kv = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scan(input int n);
    repeat (16*n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt++;
      check_val("kv_back_to_back", int'(prev_kv), 0);
    end
    prev_kv = key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    keys  = '0;
    rst_n = 1'b0;
    #22;
    @(negedge clk) rst_n = 1'b1;

    // 1: reset mid-scan with a key down
    keys[9] = 1'b1;
    repeat (24) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_col_n", int'(col_n), 4'b1110);
    check_val("rst_key_valid", int'(key_valid), 0);
    check_val("rst_key_held", int'(key_held), 0);
    check_val("rst_multi_key", int'(multi_key), 0);
    check_val("rst_key_code", int'(key_code), 0);
    keys = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("col0", int'(col_n), 4'b1110);
    repeat (4) @(posedge clk); #1 check_val("col1", int'(col_n), 4'b1101);
    repeat (4) @(posedge clk); #1 check_val("col2", int'(col_n), 4'b1011);
    repeat (4) @(posedge clk); #1 check_val("col3", int'(col_n), 4'b0111);
    repeat (4) @(posedge clk); #1 check_val("col_wrap", int'(col_n), 4'b1110);
    check_val("idle_held", int'(key_held), 0);

    // 2: press key 9 (r2,c1)
    p0 = pulse_cnt;
    keys[9] = 1'b1;
    scan(2);
    repeat (15) @(posedge clk);
    #1 check_val("t2_held_before", int'(key_held), 0);
    check_val("t2_valid_before", int'(key_valid), 0);
    @(posedge clk); #1;
    check_val("t2_valid", int'(key_valid), 1);
    check_val("t2_held", int'(key_held), 1);
    check_val("t2_code", int'(key_code), 9);
    @(posedge clk); #1 check_val("t2_valid_drop", int'(key_valid), 0);
    repeat (15) @(posedge clk);
    scan(2);
    check_val("t2_pulses", pulse_cnt - p0, 1);
    check_val("t2_still_held", int'(key_held), 1);

    // 4: release bounce then real release
    p0 = pulse_cnt;
    keys[9] = 1'b0;
    scan(1);
    check_val("t4_held_blip", int'(key_held), 1);
    keys[9] = 1'b1;
    scan(1);
    check_val("t4_held_repress", int'(key_held), 1);
    keys[9] = 1'b0;
    scan(2);
    check_val("t4_held_2scans", int'(key_held), 1);
    repeat (15) @(posedge clk);
    #1 check_val("t4_held_late", int'(key_held), 1);
    @(posedge clk); #1 check_val("t4_held_drop", int'(key_held), 0);
    check_val("t4_pulses", pulse_cnt - p0, 0);

    // 3: bounce on key 3 (r0,c3)
    p0 = pulse_cnt;
    keys[3] = 1'b1;
    scan(2);
    check_val("t3_held_mid", int'(key_held), 0);
    keys[3] = 1'b0;
    scan(2);
    check_val("t3_pulses", pulse_cnt - p0, 0);
    check_val("t3_held", int'(key_held), 0);
    check_val("t3_code", int'(key_code), 9);

    // 5: two keys together from IDLE
    p0 = pulse_cnt;
    check_val("t5_multi_before", int'(multi_key), 0);
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    scan(1);
    check_val("t5_multi", int'(multi_key), 1);
    scan(4);
    check_val("t5_pulses", pulse_cnt - p0, 0);
    check_val("t5_held", int'(key_held), 0);
    check_val("t5_code", int'(key_code), 9);
    keys = '0;
    scan(1);
    check_val("t5_multi_clear", int'(multi_key), 0);

    // 6: hold 5, add 6, release, then press 6 alone
    p0 = pulse_cnt;
    keys[5] = 1'b1;
    scan(3);
    check_val("t6_valid5", int'(key_valid), 1);
    check_val("t6_code5", int'(key_code), 5);
    scan(1);
    keys[6] = 1'b1;
    scan(1);
    check_val("t6_multi", int'(multi_key), 1);
    check_val("t6_held", int'(key_held), 1);
    scan(2);
    check_val("t6_pulses_a", pulse_cnt - p0, 1);
    check_val("t6_code_keep", int'(key_code), 5);
    keys = '0;
    scan(3);
    check_val("t6_released", int'(key_held), 0);
    check_val("t6_multi_clear", int'(multi_key), 0);
    p0 = pulse_cnt;
    keys[6] = 1'b1;
    scan(3);
    check_val("t6_valid6", int'(key_valid), 1);
    check_val("t6_code6", int'(key_code), 6);
    scan(1);
    check_val("t6_pulses_b", pulse_cnt - p0, 1);
    keys = '0;
    scan(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
